// File: rtl/packet_ingress_arbiter.sv
// Packet-level round-robin merge of NUM_PORTS sop/eop byte streams into one
// buffer write port, with max-length truncation and block statistics.
module packet_ingress_arbiter #(
  parameter int DATA_WIDTH  = 8,
  parameter int NUM_PORTS   = 4,
  parameter int MAX_PKT_LEN = 1518,
  parameter int PORT_W      = $clog2(NUM_PORTS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_data,
  input  logic [NUM_PORTS-1:0]            in_valid,
  input  logic [NUM_PORTS-1:0]            in_sop,
  input  logic [NUM_PORTS-1:0]            in_eop,
  output logic [NUM_PORTS-1:0]            in_ready,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  output logic                            out_sop,
  output logic                            out_eop,
  input  logic                            out_ready,
  output logic [NUM_PORTS-1:0]            grant,
  output logic                            busy,
  output logic [15:0]                     pkt_count,
  output logic [7:0]                      trunc_count,
  output logic [7:0]                      frame_err_count
);
  localparam int LEN_W = $clog2(MAX_PKT_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_LAST = LEN_W'(MAX_PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, XFER, DRAIN} state_t;

  state_t                state_q;
  logic [PORT_W-1:0]     last_q;
  logic [NUM_PORTS-1:0]  grant_q;
  logic [LEN_W-1:0]      len_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  vld_q, sop_q, eop_q;
  logic [15:0]           pkt_q;
  logic [7:0]            trunc_q, ferr_q;

  logic [NUM_PORTS-1:0]  req, stray, pick_oh;
  logic                  pick_vld;
  logic [PORT_W-1:0]     pick_idx;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  g_valid, g_eop, out_free, xfer_acc, at_last;

  assign req      = in_valid & in_sop;
  assign stray    = in_valid & ~in_sop;
  assign out_free = ~vld_q | out_ready;

  // Cyclic search after the last winner; descending k lets the nearest request win.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      if (req[(int'(last_q) + k) % NUM_PORTS]) begin
        pick_vld = 1'b1;
        pick_idx = PORT_W'((int'(last_q) + k) % NUM_PORTS);
      end
    end
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  // While busy, last_q is the index of the current owner.
  assign g_data   = in_data[int'(last_q)*DATA_WIDTH +: DATA_WIDTH];
  assign g_valid  = in_valid[last_q];
  assign g_eop    = in_eop[last_q];
  assign xfer_acc = (state_q == XFER) & g_valid & out_free;
  assign at_last  = (len_q == LEN_LAST);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    assign in_ready[p] = (state_q == IDLE) ? stray[p]
                       : grant_q[p] & ((state_q == DRAIN) | out_free);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= PORT_W'(NUM_PORTS - 1);
      grant_q <= '0;
      len_q   <= '0;
      data_q  <= '0;
      vld_q   <= 1'b0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      pkt_q   <= '0;
      trunc_q <= '0;
      ferr_q  <= '0;
    end else begin
      if (out_ready) vld_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (|stray && ferr_q != 8'hFF) ferr_q <= ferr_q + 8'd1;
          if (pick_vld) begin
            grant_q <= pick_oh;
            last_q  <= pick_idx;
            state_q <= XFER;
          end
        end
        XFER: begin
          if (xfer_acc) begin
            data_q <= g_data;
            sop_q  <= (len_q == '0);
            eop_q  <= g_eop | at_last;
            vld_q  <= 1'b1;
            if (g_eop) begin
              pkt_q   <= pkt_q + 16'd1;
              len_q   <= '0;
              grant_q <= '0;
              state_q <= IDLE;
            end else if (at_last) begin
              pkt_q   <= pkt_q + 16'd1;
              if (trunc_q != 8'hFF) trunc_q <= trunc_q + 8'd1;
              len_q   <= '0;
              state_q <= DRAIN;
            end else begin
              len_q <= len_q + 1'b1;
            end
          end
        end
        DRAIN: begin
          if (g_valid && g_eop) begin
            grant_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_data        = data_q;
  assign out_valid       = vld_q;
  assign out_sop         = sop_q;
  assign out_eop         = eop_q;
  assign grant           = grant_q;
  assign busy            = (state_q != IDLE);
  assign pkt_count       = pkt_q;
  assign trunc_count     = trunc_q;
  assign frame_err_count = ferr_q;

endmodule

// File: doc/packet_ingress_arbiter.md
# packet_ingress_arbiter

Packet-level round-robin arbiter that merges up to NUM_PORTS independent byte streams, each framed with sop/eop, into the single write interface of the packet buffer. A grant is held for a whole packet, so packets from different sources never interleave in the buffer. The block also enforces a maximum packet length by truncating oversize packets and draining their remainder, and it keeps per-block statistics.

## Interface
- DATA_WIDTH, 8, byte lane width
- NUM_PORTS, 4, number of requesters (2..8)
- MAX_PKT_LEN, 1518, maximum bytes per packet before forced truncation (≥2)
- PORT_W, $clog2(NUM_PORTS), grant index width
- clk  in  1  single clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  NUM_PORTS*DATA_WIDTH  port i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- in_valid / in_sop / in_eop  in  NUM_PORTS  per-port framing
- in_ready  out  NUM_PORTS  per-port accept; a byte transfers on in_valid[i] & in_ready[i]
- out_data  out  DATA_WIDTH  registered byte toward the buffer wr_data
- out_valid / out_sop / out_eop  out  1  registered framing toward the buffer
- out_ready  in  1  buffer wr_ready
- grant  out  NUM_PORTS  one-hot owner of the output, 0 when idle
- busy  out  1  state != IDLE
- pkt_count  out  16  packets emitted; wraps
- trunc_count  out  8  truncated packets; saturates at 255
- frame_err_count  out  8  non-sop bytes discarded while idle; saturates at 255

## Operation
- States: IDLE, XFER, DRAIN.
- IDLE:
  - req[i] = in_valid[i] & in_sop[i].
  - If any req is set, pick the first set index strictly after last_idx, searching cyclically. Register grant and last_idx, then go to XFER. There is one bubble cycle per packet.
  - in_ready[i] = in_valid[i] & !in_sop[i]. Such stray bytes are discarded and frame_err_count increments by 1 per cycle in which any are discarded.
- XFER:
  - in_ready[g] = !out_valid | out_ready. All other ports have in_ready = 0.
  - On an accepted byte:
    - out_data is loaded from the granted port.
    - out_sop = (len_cnt == 0).
    - out_eop = in_eop[g] | (len_cnt == MAX_PKT_LEN-1).
    - out_valid is set to 1.
    - len_cnt increments.
  - in_sop seen while len_cnt > 0 is ignored; the byte passes as data.
  - Accepted byte with in_eop: pkt_count++, len_cnt is set to 0, grant is cleared, go to IDLE.
  - Accepted byte at len_cnt == MAX_PKT_LEN-1 without in_eop: emit it with forced out_eop, pkt_count++, trunc_count++, len_cnt is set to 0, go to DRAIN.
- DRAIN:
  - in_ready[g] = 1.
  - Accepted bytes are dropped and nothing is output.
  - An accepted byte with in_eop clears grant and returns to IDLE.
- Output register: out_valid is cleared when out_ready=1 and no new byte loads that cycle. out_data, out_sop and out_eop hold while out_valid & !out_ready.
- last_idx resets to NUM_PORTS-1, so port 0 wins the first arbitration.

## Timing
- Reset values:
  - in_ready 0
  - out_data 0
  - out_valid / out_sop / out_eop 0
  - grant 0
  - busy 0
  - all counters 0
  - state IDLE
  - len_cnt 0
- in_ready is combinational from state, grant, out_valid and out_ready. All other outputs are registered.
- Latency: a byte accepted at cycle n appears on out_* at cycle n+1.
- Full throughput of 1 byte/clk within a packet while out_ready=1.
- Minimum inter-packet gap is 1 cycle (IDLE).
- Backpressure: with out_valid=1 and out_ready=0, no input byte is accepted and the output holds stable.
- A single-byte packet (sop & eop) goes IDLE→XFER→IDLE and emits out_sop = out_eop = 1.
- When an eop byte and a new sop request coincide, arbitration happens only in the following IDLE cycle.
- len_cnt is $clog2(MAX_PKT_LEN+1) bits wide and never exceeds MAX_PKT_LEN-1.
- An asserted rst_n mid-packet returns everything to reset values immediately. The partial packet is lost and no eop is emitted.

## Test plan
- Ports 0 and 2 each present a 4-byte packet at t=0 → port 0 packet first, then port 2.
  - out bytes are contiguous within each packet, with one idle cycle between packets.
  - pkt_count=2, grant sequence 0001, 0000, 0100.
- All 4 ports continuously requesting for 8 packets → grant order 0,1,2,3,0,1,2,3; each output packet's bytes come from a single port.
- MAX_PKT_LEN=8, port 1 sends 12 bytes → the 8th output byte carries out_eop=1.
  - The remaining 4 input bytes are accepted and dropped.
  - trunc_count=1, pkt_count=1, state IDLE after the input eop.
- out_ready held low for 5 cycles mid-packet → out_* is stable, in_ready[g]=0, and no bytes are lost or duplicated after release.
- 3 non-sop bytes on port 3 while idle, then a valid packet → frame_err_count=3 and the packet passes intact.
- rst_n pulsed low during byte 3 of a packet → the next cycle has all outputs at reset values, and a following packet from port 0 is emitted normally.
